uart_host_ctrl: RTL and testbench
=================================

Name: uart_host_ctrl

Overview:
Host-side initiator for the UART core's parallel control port. It converts single-beat commands from an upstream sequencer or CPU into correctly timed control strobes: register write, register read, and byte transmit with wait-for-receive. It returns one response per command over a valid/ready channel. It sits between the system bus and the UART core, and owns all strobe-width and settle timing.

Parameters:
STROBE_CYCLES, 4, cycles each active strobe is held; must be at least 3 so the strobe crosses the core's 2-flop input synchronisers.
SETTLE_CYCLES, 4, cycles waited after strobe release before sampling i_data and responding.
TIMEOUT_CYCLES, 1000000, maximum cycles to wait for i_ready (before TX) or i_rx_valid (after TX).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  command accepted when valid and ready are both high
i_cmd_op  in  2  00 write reg, 01 read reg, 10 send byte, 11 reserved
i_cmd_addr  in  4  core register address
i_cmd_data  in  9  write data or TX byte
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed
o_rsp_data  out  9  read or RX data
o_rsp_status  out  2  00 ok, 01 rx error, 10 timeout, 11 bad op
o_request_tx  out  1  to core, active-high TX request
o_ws_n  out  1  to core, write strobe, active-low
o_rs_n  out  1  to core, read strobe, active-low
o_addr  out  4  to core
o_data  out  9  to core
i_data  in  9  from core data output
i_ready  in  1  from core TX ready
i_rx_error  in  1  from core
i_rx_valid  in  1  from core
o_busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset values (asynchronous, active-low):
  - o_request_tx=0, o_ws_n=1, o_rs_n=1.
  - o_addr=0, o_data=0.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_status=0.
  - o_cmd_ready=0 while in reset; o_cmd_ready=1 from the first clock after reset release.
  - FSM goes to IDLE.
- FSM states are one-hot: IDLE, WAIT_RDY, STROBE, SETTLE, WAIT_RX, RESP.
- IDLE:
  - o_cmd_ready=1.
  - On handshake, latch op, addr and data. o_addr/o_data update on the next edge and stay stable until RESP exits.
- Transitions from IDLE:
  - op 11 → RESP with status 11, data 0, no strobe.
  - op 10 → WAIT_RDY.
  - op 00/01 → STROBE.
- WAIT_RDY:
  - Stay while i_ready=0; go to STROBE when i_ready=1.
  - If the timeout counter reaches TIMEOUT_CYCLES → RESP with status 10.
- STROBE:
  - Drive exactly one strobe for STROBE_CYCLES cycles: o_ws_n=0 (op 00), o_rs_n=0 (op 01), or o_request_tx=1 (op 10).
  - Then release the strobe.
  - Next state: SETTLE for op 00/01; WAIT_RX for op 10.
- WAIT_RX:
  - Counter restarts.
  - Sticky-capture i_rx_error=1 during this state.
  - On i_rx_valid=1 → SETTLE.
  - If the counter reaches TIMEOUT_CYCLES → RESP with status 10 and data 0. The core stays in its TX/RX wait; recovery is by system reset, and this controller does not reset the core.
- SETTLE:
  - Wait SETTLE_CYCLES cycles, then latch i_data into o_rsp_data.
  - op 00 always forces o_rsp_data=0.
  - Status: 01 if sticky rx error is set, else 00.
  - Next state: RESP.
- RESP:
  - o_rsp_valid=1; o_rsp_data/o_rsp_status stay stable until i_rsp_ready=1.
  - On handshake: o_rsp_valid=0 on the next edge and state goes to IDLE.
  - Backpressure may last indefinitely with no loss.
- Ordering and overlap:
  - Only one command is outstanding.
  - o_cmd_ready=0 in every state except IDLE, so there is no command/response overlap.
  - Earliest next acceptance is the cycle after the response handshake.
- Latency, with the accept edge as cycle 0:
  - Write/read: strobe active cycles 1..S; o_rsp_valid rises at cycle S+T+1 (S=STROBE_CYCLES, T=SETTLE_CYCLES).
  - Bad op: o_rsp_valid at cycle 1.
- Counter: single down-counter, width $clog2(TIMEOUT_CYCLES+1), loaded on each state entry, saturating at 0.
- Strobe rule: strobes are mutually exclusive and never asserted outside STROBE.
- i_rx_valid seen outside WAIT_RX is ignored.
- Reset mid-operation: strobes release immediately (asynchronously), any pending response is dropped, and the FSM goes to IDLE.

Decomposition:
- Package uart_host_pkg:
  - op codes OP_WR, OP_RD, OP_TX, OP_RSVD;
  - status codes ST_OK, ST_RXERR, ST_TIMEOUT, ST_BADOP;
  - one-hot state localparams.
- One sub-module, uart_host_timer: loadable saturating down-counter with a done flag, shared by the strobe, settle and timeout phases.

Test Plan:
- Write op 00, addr 7, data 0x00A, S=4, T=4 → o_ws_n low for exactly cycles 1–4, o_addr=7, o_data=0x00A; response at cycle 9 with status 00, data 0x000.
- Read op 01, addr 4, core model returns 0x0B9 → o_rs_n low 4 cycles; response data 0x0B9, status 00.
- Send op 10, data 0x055, i_ready=1, model raises i_rx_valid 200 cycles later with i_data=0x055 → o_request_tx high 4 cycles; response data 0x055, status 00. Repeat with i_rx_error pulsed → status 01.
- Send with i_ready held 0, TIMEOUT_CYCLES=50 → no strobe; response status 10 at cycle 51.
- Op 11 → response at cycle 1, status 11, no strobe toggles; then hold i_rsp_ready=0 for 20 cycles → response held stable, o_cmd_ready=0 throughout.
- Assert i_rst_n=0 during a write strobe at cycle 2 → o_ws_n=1 immediately; after release: o_cmd_ready=1, o_rsp_valid=0, no response emitted.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared op codes, response status codes and one-hot FSM encoding for the
// UART host control-port initiator.
package uart_host_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_TX   = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_RXERR   = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_BADOP   = 2'b11
  } status_t;

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_WAIT_RDY = 6'b000010,
    S_STROBE   = 6'b000100,
    S_SETTLE   = 6'b001000,
    S_WAIT_RX  = 6'b010000,
    S_RESP     = 6'b100000
  } state_t;

endpackage

// File: rtl/uart_host_timer.sv
// Loadable down-counter that saturates at zero; o_done is high while the count is zero.
module uart_host_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side initiator for the UART core control port: turns single-beat commands
// into timed strobes and returns exactly one response per command.
module uart_host_ctrl
  import uart_host_pkg::*;
#(
  parameter int STROBE_CYCLES  = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [3:0] i_cmd_addr,
  input  logic [8:0] i_cmd_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [8:0] o_rsp_data,
  output logic [1:0] o_rsp_status,
  output logic       o_request_tx,
  output logic       o_ws_n,
  output logic       o_rs_n,
  output logic [3:0] o_addr,
  output logic [8:0] o_data,
  input  logic [8:0] i_data,
  input  logic       i_ready,
  input  logic       i_rx_error,
  input  logic       i_rx_valid,
  output logic       o_busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LD_STROBE  = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] LD_SETTLE  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_state_nxt;
  op_t             r_op, w_op;
  logic            r_rx_err;
  logic            w_accept, w_load, w_done, w_strobe_nxt;
  logic [CW-1:0]   w_load_val;

  // Both channels: a beat transfers on the rising edge where valid and ready are
  // both high; the sender holds its payload stable until that edge.
  assign w_accept     = i_cmd_valid & o_cmd_ready;
  assign w_op         = (r_state == S_IDLE) ? op_t'(i_cmd_op) : r_op;
  assign w_strobe_nxt = (w_state_nxt == S_STROBE);
  assign o_busy       = (r_state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        case (op_t'(i_cmd_op))
          OP_RSVD: w_state_nxt = S_RESP;
          OP_TX:   w_state_nxt = S_WAIT_RDY;
          default: w_state_nxt = S_STROBE;
        endcase
      end
      S_WAIT_RDY: if (i_ready) w_state_nxt = S_STROBE;
                  else if (w_done) w_state_nxt = S_RESP;
      S_STROBE:   if (w_done) w_state_nxt = (r_op == OP_TX) ? S_WAIT_RX : S_SETTLE;
      S_SETTLE:   if (w_done) w_state_nxt = S_RESP;
      S_WAIT_RX:  if (i_rx_valid) w_state_nxt = S_SETTLE;
                  else if (w_done) w_state_nxt = S_RESP;
      S_RESP:     if (i_rsp_ready) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Every state entry reloads the shared timer with that phase's length minus one.
  always_comb begin
    w_load_val = '0;
    case (w_state_nxt)
      S_WAIT_RDY, S_WAIT_RX: w_load_val = LD_TIMEOUT;
      S_STROBE:              w_load_val = LD_STROBE;
      S_SETTLE:              w_load_val = LD_SETTLE;
      default:               w_load_val = '0;
    endcase
  end

  assign w_load = (w_state_nxt != r_state);

  uart_host_timer #(.W(CW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op         <= OP_WR;
      r_rx_err     <= 1'b0;
      o_cmd_ready  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_status <= ST_OK;
      o_request_tx <= 1'b0;
      o_ws_n       <= 1'b1;
      o_rs_n       <= 1'b1;
      o_addr       <= '0;
      o_data       <= '0;
    end else begin
      o_cmd_ready  <= (w_state_nxt == S_IDLE);
      o_rsp_valid  <= (w_state_nxt == S_RESP);
      o_ws_n       <= !(w_strobe_nxt && (w_op == OP_WR));
      o_rs_n       <= !(w_strobe_nxt && (w_op == OP_RD));
      o_request_tx <= w_strobe_nxt && (w_op == OP_TX);
      if (w_accept) begin
        r_op     <= op_t'(i_cmd_op);
        o_addr   <= i_cmd_addr;
        o_data   <= i_cmd_data;
        r_rx_err <= 1'b0;
      end else if ((r_state == S_WAIT_RX) && i_rx_error) begin
        r_rx_err <= 1'b1;
      end
      // Response payload is captured once on RESP entry and held through backpressure.
      if ((w_state_nxt == S_RESP) && (r_state != S_RESP)) begin
        case (r_state)
          S_SETTLE: begin
            o_rsp_data   <= (r_op == OP_WR) ? 9'd0 : i_data;
            o_rsp_status <= r_rx_err ? ST_RXERR : ST_OK;
          end
          S_IDLE: begin
            o_rsp_data   <= '0;
            o_rsp_status <= ST_BADOP;
          end
          default: begin
            o_rsp_data   <= '0;
            o_rsp_status <= ST_TIMEOUT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: per-command timeline model (strobe window, response
// cycle, payload) checked every cycle, plus directed literal pins and random commands.
module tb_uart_host_ctrl;

  localparam int S  = 4;
  localparam int T  = 4;
  localparam int TO = 250;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op = 2'b00;
  logic [3:0] i_cmd_addr = 4'h0;
  logic [8:0] i_cmd_data = 9'h000;
  logic       o_rsp_valid;
  logic       i_rsp_ready = 1'b0;
  logic [8:0] o_rsp_data;
  logic [1:0] o_rsp_status;
  logic       o_request_tx, o_ws_n, o_rs_n;
  logic [3:0] o_addr;
  logic [8:0] o_data;
  logic [8:0] i_data = 9'h000;
  logic       i_ready = 1'b0;
  logic       i_rx_error = 1'b0;
  logic       i_rx_valid = 1'b0;
  logic       o_busy;

  uart_host_ctrl #(.STROBE_CYCLES(S), .SETTLE_CYCLES(T), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_status(o_rsp_status), .o_request_tx(o_request_tx), .o_ws_n(o_ws_n),
    .o_rs_n(o_rs_n), .o_addr(o_addr), .o_data(o_data), .i_data(i_data),
    .i_ready(i_ready), .i_rx_error(i_rx_error), .i_rx_valid(i_rx_valid), .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model state ----------------
  bit         mon_en = 1'b0;
  bit         e_act = 1'b0;
  int         e_acc, e_slo, e_shi, e_rsp, e_end;
  logic [1:0] e_op, e_st;
  logic [3:0] e_addr;
  logic [8:0] e_wdata, e_rdata;

  // observations of the DUT used only by the directed literal pins
  bit obs_seen;
  int obs_rsp_cyc, obs_ws, obs_rs, obs_tx, obs_vcnt;
  logic [8:0] obs_data;
  logic [1:0] obs_st;

  bit m_busy, m_strobe, m_valid;

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    if (mon_en) begin
      m_busy   = e_act && (cyc >= e_acc + 1) && (cyc <= e_end);
      m_strobe = e_act && (cyc >= e_slo) && (cyc <= e_shi);
      m_valid  = e_act && (cyc >= e_rsp) && (cyc <= e_end);
      chk("busy", o_busy, m_busy);
      chk("cmd_ready", o_cmd_ready, !m_busy);
      chk("ws_n", o_ws_n, !(m_strobe && e_op == 2'b00));
      chk("rs_n", o_rs_n, !(m_strobe && e_op == 2'b01));
      chk("request_tx", o_request_tx, m_strobe && e_op == 2'b10);
      chk("rsp_valid", o_rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_data", o_rsp_data, e_rdata);
        chk("rsp_status", o_rsp_status, e_st);
      end
      if (e_act && cyc >= e_acc + 1) begin
        chk("core_addr", o_addr, e_addr);
        chk("core_data", o_data, e_wdata);
      end
      if (o_rsp_valid && !obs_seen) begin
        obs_seen    = 1'b1;
        obs_rsp_cyc = cyc - e_acc;
        obs_data    = o_rsp_data;
        obs_st      = o_rsp_status;
      end
      if (o_rsp_valid) obs_vcnt++;
      if (!o_ws_n) obs_ws++;
      if (!o_rs_n) obs_rs++;
      if (o_request_tx) obs_tx++;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // rdy_dly/rx_at/err_at/rst_at are cycles after the accept cycle (0 = never);
  // hold < 0 gives random response backpressure, else i_rsp_ready rises hold cycles late.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [8:0] wdata,
                         input int rdy_dly, input int rx_at, input int err_at,
                         input logic [8:0] core, input int hold, input int rst_at);
    int  w, m, guard;
    bit  done;
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_addr = addr; i_cmd_data = wdata;
    i_ready = 1'b0; i_rx_valid = 1'b0; i_rx_error = 1'b0; i_data = core; i_rsp_ready = 1'b0;
    e_acc = cyc; e_op = op; e_addr = addr; e_wdata = wdata; e_end = 32'h7fffffff;
    e_slo = 1; e_shi = 0; e_rdata = 9'h000;
    case (op)
      2'b00, 2'b01: begin
        e_slo = cyc + 1; e_shi = cyc + S; e_rsp = cyc + S + T + 1; e_st = 2'b00;
        e_rdata = (op == 2'b01) ? core : 9'h000;
      end
      2'b11: begin e_rsp = cyc + 1; e_st = 2'b11; end
      default: begin
        if (rdy_dly == 0 || rdy_dly > TO) begin
          e_rsp = cyc + TO + 1; e_st = 2'b10;
        end else begin
          e_slo = cyc + rdy_dly + 1; e_shi = cyc + rdy_dly + S;
          w = cyc + rdy_dly + S + 1;
          m = cyc + rx_at;
          if (rx_at != 0 && m >= w && m <= w + TO - 1) begin
            e_rsp = m + T + 1; e_rdata = core;
            e_st = (err_at != 0 && cyc + err_at >= w && cyc + err_at <= m) ? 2'b01 : 2'b00;
          end else begin
            e_rsp = w + TO; e_st = 2'b10;
          end
        end
      end
    endcase
    e_act = 1'b1;
    obs_seen = 1'b0; obs_ws = 0; obs_rs = 0; obs_tx = 0; obs_vcnt = 0;
    tick();
    done = 1'b0; guard = 0;
    while (!done && guard < 2000) begin
      i_cmd_valid = 1'($urandom_range(0, 1));
      i_cmd_op    = 2'($urandom);
      i_cmd_addr  = 4'($urandom);
      i_cmd_data  = 9'($urandom);
      i_ready     = (rdy_dly != 0) && (cyc >= e_acc + rdy_dly);
      i_rx_valid  = (rx_at != 0) && (cyc == e_acc + rx_at);
      i_rx_error  = (err_at != 0) && (cyc == e_acc + err_at);
      if (rst_at != 0 && cyc == e_acc + rst_at) begin
        mon_en = 1'b0; i_cmd_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("rst_ws_n", o_ws_n, 1'b1);
        chk("rst_rsp_valid", o_rsp_valid, 1'b0);
        chk("rst_cmd_ready", o_cmd_ready, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_addr", o_addr, 4'h0);
        tick(); tick();
        i_rst_n = 1'b1; e_act = 1'b0;
        tick();
        mon_en = 1'b1; obs_seen = 1'b0;
        done = 1'b1;
      end else begin
        if (cyc >= e_rsp) i_rsp_ready = (hold < 0) ? 1'($urandom_range(0, 1)) : (cyc >= e_rsp + hold);
        else              i_rsp_ready = 1'($urandom_range(0, 1));
        if (cyc >= e_rsp && i_rsp_ready) begin
          e_end = cyc; done = 1'b1;
        end
        tick();
      end
      guard++;
    end
    i_cmd_valid = 1'b0; i_ready = 1'b0; i_rx_valid = 1'b0; i_rx_error = 1'b0; i_rsp_ready = 1'b0;
    chk("rsp_handshake", done, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] op;
    int rdy, rx_at, err_at, base, hold;
    #2 i_rst_n = 1'b0;
    #1;
    chk("reset_request_tx", o_request_tx, 1'b0);
    chk("reset_ws_n", o_ws_n, 1'b1);
    chk("reset_rs_n", o_rs_n, 1'b1);
    chk("reset_addr", o_addr, 4'h0);
    chk("reset_data", o_data, 9'h000);
    chk("reset_rsp_valid", o_rsp_valid, 1'b0);
    chk("reset_rsp_data", o_rsp_data, 9'h000);
    chk("reset_rsp_status", o_rsp_status, 2'b00);
    chk("reset_cmd_ready", o_cmd_ready, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    repeat (3) tick();
    i_rst_n = 1'b1;
    chk("release_cmd_ready", o_cmd_ready, 1'b0);
    tick();
    mon_en = 1'b1;

    // write addr 7, data 0x00A
    run_cmd(2'b00, 4'h7, 9'h00A, 0, 0, 0, 9'h1FF, 0, 0);
    chk("wr_rsp_cycle", obs_rsp_cyc, 9);
    chk("wr_ws_cycles", obs_ws, 4);
    chk("wr_rsp_data", obs_data, 9'h000);
    chk("wr_rsp_status", obs_st, 2'b00);

    // read addr 4, core returns 0x0B9
    run_cmd(2'b01, 4'h4, 9'h000, 0, 0, 0, 9'h0B9, 2, 0);
    chk("rd_rs_cycles", obs_rs, 4);
    chk("rd_rsp_data", obs_data, 9'h0B9);
    chk("rd_rsp_status", obs_st, 2'b00);

    // send 0x055, rx_valid 200 cycles after strobe release
    run_cmd(2'b10, 4'h0, 9'h055, 1, 5 + 200, 0, 9'h055, 0, 0);
    chk("tx_req_cycles", obs_tx, 4);
    chk("tx_rsp_cycle", obs_rsp_cyc, 210);
    chk("tx_rsp_data", obs_data, 9'h055);
    chk("tx_rsp_status", obs_st, 2'b00);

    // same, with rx_error pulsed while waiting for receive
    run_cmd(2'b10, 4'h0, 9'h055, 1, 5 + 200, 100, 9'h055, 0, 0);
    chk("txerr_rsp_status", obs_st, 2'b01);

    // send with i_ready never asserted
    run_cmd(2'b10, 4'h2, 9'h0AA, 0, 0, 0, 9'h000, 0, 0);
    chk("tmo_req_cycles", obs_tx, 0);
    chk("tmo_rsp_cycle", obs_rsp_cyc, TO + 1);
    chk("tmo_rsp_status", obs_st, 2'b10);

    // reserved op with 20 cycles of backpressure
    run_cmd(2'b11, 4'h9, 9'h123, 0, 3, 0, 9'h0FF, 20, 0);
    chk("bad_rsp_cycle", obs_rsp_cyc, 1);
    chk("bad_rsp_status", obs_st, 2'b11);
    chk("bad_strobes", obs_ws + obs_rs + obs_tx, 0);
    chk("bad_valid_cycles", obs_vcnt, 21);

    // reset during cycle 2 of a write strobe
    run_cmd(2'b00, 4'h7, 9'h00A, 0, 0, 0, 9'h000, 0, 2);
    i_rsp_ready = 1'b1;
    repeat (20) tick();
    i_rsp_ready = 1'b0;
    chk("rst_no_rsp", obs_seen, 1'b0);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom);
      hold = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 5));
      if (op == 2'b10) begin
        rdy    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
        base   = rdy + S + 1;
        rx_at  = ($urandom_range(0, 9) == 0) ? 0 : base + int'($urandom_range(0, 30));
        err_at = ($urandom_range(0, 1) == 0) ? 0 : base - 2 + int'($urandom_range(0, 12));
      end else begin
        rdy    = int'($urandom_range(0, 3));
        rx_at  = int'($urandom_range(1, 12));
        err_at = int'($urandom_range(0, 12));
      end
      run_cmd(op, 4'($urandom), 9'($urandom), rdy, rx_at, err_at, 9'($urandom), hold, 0);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
